// File: rtl/board_pkg.sv
// Shared constants, FSM state encoding and helpers for the drop-game board controller.
package board_pkg;

    localparam int ROWS_DEF    = 6;
    localparam int COLS_DEF    = 7;
    localparam int PLAYERS_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One action decoded per cycle from the button pulses.
    typedef struct packed {
        logic left;
        logic right;
        logic commit;
        logic err;
    } act_t;

    // Width of an index that can address v items, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/board_cursor.sv
// One-hot column cursor with wrap-around left/right moves.
// Optional macro BOARD_SKIP_FULL_EN: moves skip over full columns (wrapping);
// if every other column is full the cursor holds.
module board_cursor
    import board_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic            clk,
    input  logic            reset,
`ifdef BOARD_SKIP_FULL_EN
    input  logic [COLS-1:0] col_full,
`endif
    input  logic            move_left,
    input  logic            move_right,
    output logic [COLS-1:0] cursor
);

    logic [COLS-1:0] step_l;
    logic [COLS-1:0] step_r;
    logic [COLS-1:0] cursor_nxt;
`ifdef BOARD_SKIP_FULL_EN
    logic [COLS-1:0] cand;
`endif

    // Left is toward the MSB; a right move by k is a left rotate by COLS-k.
    function automatic logic [COLS-1:0] rotl(input logic [COLS-1:0] v, input int k);
        return (v << k) | (v >> (COLS - k));
    endfunction

    // Candidate positions for each direction; the nearest usable one wins.
    always_comb begin
        step_l = cursor;
        step_r = cursor;
`ifdef BOARD_SKIP_FULL_EN
        cand = '0;
        // Walk from the farthest distance down so the closest free column is kept last.
        for (int k = COLS - 1; k >= 1; k--) begin
            cand = rotl(cursor, k);
            if ((cand & col_full) == '0) step_l = cand;
            cand = rotl(cursor, COLS - k);
            if ((cand & col_full) == '0) step_r = cand;
        end
`else
        step_l = rotl(cursor, 1);
        step_r = rotl(cursor, COLS - 1);
`endif
        cursor_nxt = move_left ? step_l : (move_right ? step_r : cursor);
    end

    // Cursor register; comes out of reset on the leftmost column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cursor <= COLS'(1) << (COLS - 1);
        else        cursor <= cursor_nxt;
    end

endmodule

// File: rtl/board_drop_ctrl.sv
// Drop-game board controller: turn FSM, per-column heights, cell occupancy/owner.
// Optional macro BOARD_SKIP_FULL_EN makes cursor moves skip full columns.
module board_drop_ctrl
    import board_pkg::*;
#(
    parameter  int ROWS    = ROWS_DEF,
    parameter  int COLS    = COLS_DEF,
    parameter  int PLAYERS = PLAYERS_DEF,
    localparam int PW      = clog2_min1(PLAYERS),
    localparam int RW      = clog2_min1(ROWS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_enter,
    input  logic                    clear,
    input  logic [PW-1:0]           player,
    output logic [COLS-1:0]         cursor,
    output logic [ROWS*COLS-1:0]    occupied,
    output logic [ROWS*COLS*PW-1:0] owner,
    output logic [RW-1:0]           drop_row,
    output logic                    turn_done,
    output logic                    err_full,
    output logic                    board_full
);

    localparam int HW  = $clog2(ROWS + 1);
    localparam int CIW = clog2_min1(COLS);
    localparam int NC  = ROWS * COLS;
    localparam int CW  = clog2_min1(NC);
    localparam int OW  = clog2_min1(NC * PW);

    state_t                    state_q, state_d;
    act_t                      act;
    logic [COLS-1:0][HW-1:0]   height;
    logic [COLS-1:0]           col_full;
    logic [CIW-1:0]            cidx;
    logic                      valid_player;
    logic [CW-1:0]             cell_idx;
    logic [OW-1:0]             own_idx;

    // Column fill flags, encoded cursor column and target cell address.
    always_comb begin
        col_full = '0;
        cidx     = '0;
        for (int c = 0; c < COLS; c++) begin
            col_full[c] = (height[c] == HW'(ROWS));
            if (cursor[c]) cidx = CIW'(c);
        end
        valid_player = ({1'b0, player} < (PW + 1)'(PLAYERS));
        cell_idx     = CW'(height[cidx]) * CW'(COLS) + CW'(cidx);
        own_idx      = OW'(cell_idx) * OW'(PW);
    end

    assign board_full = &col_full;

    // Next state and the single action taken this cycle (clear overrides everything).
    always_comb begin
        state_d = state_q;
        act     = '0;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_SELECT;
                end
                ST_SELECT: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (btn_left) begin
                        act.left = 1'b1;
                    end else if (btn_right) begin
                        act.right = 1'b1;
                    end else if (btn_enter) begin
                        if (!col_full[cidx] && valid_player) begin
                            act.commit = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            act.err = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Turn state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Board contents, heights and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupied  <= '0;
            owner     <= '0;
            height    <= '0;
            drop_row  <= '0;
            turn_done <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            turn_done <= act.commit;
            err_full  <= act.err;
            if (clear) begin
                occupied <= '0;
                owner    <= '0;
                height   <= '0;
                drop_row <= '0;
            end else if (act.commit) begin
                occupied[cell_idx]     <= 1'b1;
                owner[own_idx +: PW]   <= player;
                height[cidx]           <= height[cidx] + 1'b1;
                drop_row               <= RW'(height[cidx]);
            end
        end
    end

    board_cursor #(
        .COLS       (COLS)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
`ifdef BOARD_SKIP_FULL_EN
        .col_full   (col_full),
`endif
        .move_left  (act.left),
        .move_right (act.right),
        .cursor     (cursor)
    );

endmodule

// File: tb/tb_board_drop_ctrl.sv
// Directed bench for board_drop_ctrl at default size (6x7, 2 players).
module tb_board_drop_ctrl;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_enter = 1'b0;
    logic        clear = 1'b0;
    logic [0:0]  player = '0;
    logic [6:0]  cursor;
    logic [41:0] occupied;
    logic [41:0] owner;
    logic [2:0]  drop_row;
    logic        turn_done;
    logic        err_full;
    logic        board_full;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [41:0] m_occ = '0;
    logic [41:0] m_own = '0;
    int          hgt[7];

    typedef struct {
        logic        en, l, r, e, ply;
        logic [6:0]  cur;
        logic        td, ef;
        logic [2:0]  row;
        logic [41:0] occ, own;
        state_t      st;
    } vec_t;

    vec_t tv[14];

    always #5 clk = ~clk;

    board_drop_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_enter  (btn_enter),
        .clear      (clear),
        .player     (player),
        .cursor     (cursor),
        .occupied   (occupied),
        .owner      (owner),
        .drop_row   (drop_row),
        .turn_done  (turn_done),
        .err_full   (err_full),
        .board_full (board_full)
    );

    function automatic vec_t mkv(input logic en, l, r, e, ply, input logic [6:0] cur,
                                 input logic td, ef, input logic [2:0] row,
                                 input logic [41:0] occ, own, input state_t st);
        vec_t v;
        v.en = en; v.l = l; v.r = r; v.e = e; v.ply = ply;
        v.cur = cur; v.td = td; v.ef = ef; v.row = row;
        v.occ = occ; v.own = own; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input state_t s);
        chk(nm, 64'(dut.state_q), 64'(s));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic l, input logic r, input logic e);
        btn_left = l; btn_right = r; btn_enter = e;
        cyc();
        btn_left = 1'b0; btn_right = 1'b0; btn_enter = 1'b0;
    endtask

    task automatic model_reset();
        m_occ = '0;
        m_own = '0;
        for (int c = 0; c < 7; c++) hgt[c] = 0;
    endtask

    // Enter into column c (cursor already there, state SELECT); ends back in SELECT.
    task automatic drop(input int c, input logic ply);
        int idx;
        player = ply;
        press(1'b0, 1'b0, 1'b1);
        if (hgt[c] < 6) begin
            idx = hgt[c] * 7 + c;
            m_occ[idx] = 1'b1;
            m_own[idx] = ply;
            chk("drop_turn_done", 64'(turn_done), 64'd1);
            chk("drop_row", 64'(drop_row), 64'(hgt[c]));
            chk("drop_occupied", 64'(occupied), 64'(m_occ));
            chk("drop_owner", 64'(owner), 64'(m_own));
            chk_state("drop_state_done", ST_DONE);
            hgt[c]++;
            cyc();
            chk("drop_turn_done_end", 64'(turn_done), 64'd0);
            enable = 1'b0; cyc();
            enable = 1'b1; cyc();
            chk_state("drop_state_reselect", ST_SELECT);
        end else begin
            chk("full_err", 64'(err_full), 64'd1);
            chk("full_turn_done", 64'(turn_done), 64'd0);
            chk("full_occupied", 64'(occupied), 64'(m_occ));
            chk("full_owner", 64'(owner), 64'(m_own));
            chk_state("full_state_select", ST_SELECT);
            cyc();
            chk("full_err_end", 64'(err_full), 64'd0);
        end
    endtask

    initial begin
        logic [41:0] b6;
        b6 = 42'd1 << 6;
        // en l r e ply  cursor  td ef row occ own state
        tv[0]  = mkv(1,0,0,0,0, 7'h40, 0,0,0, '0, '0, ST_SELECT);
        tv[1]  = mkv(1,1,0,0,0, 7'h01, 0,0,0, '0, '0, ST_SELECT);
        tv[2]  = mkv(1,1,0,0,0, 7'h02, 0,0,0, '0, '0, ST_SELECT);
        tv[3]  = mkv(1,1,0,0,0, 7'h04, 0,0,0, '0, '0, ST_SELECT);
        tv[4]  = mkv(1,1,0,0,0, 7'h08, 0,0,0, '0, '0, ST_SELECT);
        tv[5]  = mkv(1,1,0,0,0, 7'h10, 0,0,0, '0, '0, ST_SELECT);
        tv[6]  = mkv(1,1,0,0,0, 7'h20, 0,0,0, '0, '0, ST_SELECT);
        tv[7]  = mkv(1,1,0,0,0, 7'h40, 0,0,0, '0, '0, ST_SELECT);
        tv[8]  = mkv(1,0,0,1,1, 7'h40, 1,0,0, b6, b6, ST_DONE);
        tv[9]  = mkv(1,0,0,0,0, 7'h40, 0,0,0, b6, b6, ST_DONE);
        tv[10] = mkv(1,1,0,0,0, 7'h40, 0,0,0, b6, b6, ST_DONE);
        tv[11] = mkv(0,0,0,0,0, 7'h40, 0,0,0, b6, b6, ST_IDLE);
        tv[12] = mkv(0,0,1,0,0, 7'h40, 0,0,0, b6, b6, ST_IDLE);
        tv[13] = mkv(1,0,1,0,0, 7'h40, 0,0,0, b6, b6, ST_SELECT);

        model_reset();

        // Reset values.
        cyc(); cyc();
        chk("rst_cursor", 64'(cursor), 64'h40);
        chk("rst_occupied", 64'(occupied), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_drop_row", 64'(drop_row), 64'd0);
        chk("rst_turn_done", 64'(turn_done), 64'd0);
        chk("rst_err_full", 64'(err_full), 64'd0);
        chk("rst_board_full", 64'(board_full), 64'd0);
        chk_state("rst_state", ST_IDLE);
        reset = 1'b1;

        // Cursor walk, first drop, ignored buttons outside SELECT.
        for (int i = 0; i < 14; i++) begin
            enable = tv[i].en; player = tv[i].ply;
            btn_left = tv[i].l; btn_right = tv[i].r; btn_enter = tv[i].e;
            cyc();
            btn_left = 1'b0; btn_right = 1'b0; btn_enter = 1'b0;
            chk($sformatf("vec%0d_cursor", i), 64'(cursor), 64'(tv[i].cur));
            chk($sformatf("vec%0d_turn_done", i), 64'(turn_done), 64'(tv[i].td));
            chk($sformatf("vec%0d_err_full", i), 64'(err_full), 64'(tv[i].ef));
            chk($sformatf("vec%0d_drop_row", i), 64'(drop_row), 64'(tv[i].row));
            chk($sformatf("vec%0d_occupied", i), 64'(occupied), 64'(tv[i].occ));
            chk($sformatf("vec%0d_owner", i), 64'(owner), 64'(tv[i].own));
            chk($sformatf("vec%0d_state", i), 64'(dut.state_q), 64'(tv[i].st));
        end
        m_occ[6] = 1'b1; m_own[6] = 1'b1; hgt[6] = 1;

        // Fill column 3, then one enter too many.
        press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
        chk("col3_cursor", 64'(cursor), 64'h08);
        for (int i = 0; i < 6; i++) drop(3, 1'(i % 2));
        chk("col3_height_row", 64'(drop_row), 64'd5);
        drop(3, 1'b0);

        // Left and enter together: only the cursor moves.
        press(1, 0, 1);
        chk("left_enter_cursor", 64'(cursor), 64'h10);
        chk("left_enter_occupied", 64'(occupied), 64'(m_occ));
        chk("left_enter_turn_done", 64'(turn_done), 64'd0);
        chk_state("left_enter_state", ST_SELECT);

        // Asynchronous reset in the middle of a turn with a button pending.
        btn_left = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("midrst_cursor", 64'(cursor), 64'h40);
        chk("midrst_occupied", 64'(occupied), 64'd0);
        chk("midrst_owner", 64'(owner), 64'd0);
        chk("midrst_drop_row", 64'(drop_row), 64'd0);
        chk("midrst_turn_done", 64'(turn_done), 64'd0);
        chk("midrst_err_full", 64'(err_full), 64'd0);
        chk_state("midrst_state", ST_IDLE);
        @(negedge clk);
        btn_left = 1'b0;
        cyc();
        chk("midrst_hold_cursor", 64'(cursor), 64'h40);
        reset = 1'b1;
        model_reset();
        cyc();
        chk_state("postrst_select", ST_SELECT);

        // Fill columns 5 and 4, return to column 6, then step right.
        press(0, 1, 0);
        chk("skip_col5", 64'(cursor), 64'h20);
        for (int i = 0; i < 6; i++) drop(5, 1'b1);
        press(0, 1, 0);
        chk("skip_col4", 64'(cursor), 64'h10);
        for (int i = 0; i < 6; i++) drop(4, 1'b0);
        press(1, 0, 0);
`ifdef BOARD_SKIP_FULL_EN
        chk("skip_left", 64'(cursor), 64'h40);
`else
        chk("noskip_left", 64'(cursor), 64'h20);
        press(1, 0, 0);
        chk("noskip_left2", 64'(cursor), 64'h40);
`endif
        press(0, 1, 0);
`ifdef BOARD_SKIP_FULL_EN
        chk("skip_right", 64'(cursor), 64'h08);
`else
        chk("noskip_right", 64'(cursor), 64'h20);
`endif

        // Whole-board fill then clear with a coincident button.
        reset = 1'b0; cyc(); reset = 1'b1;
        model_reset();
        enable = 1'b1; cyc();
        for (int c = 6; c >= 0; c--) begin
            for (int k = 0; k < 6; k++) begin
                if (c == 0 && k == 5) chk("fill_not_full", 64'(board_full), 64'd0);
                drop(c, 1'(c % 2));
            end
            if (c > 0) begin
                press(0, 1, 0);
                chk($sformatf("fill_cursor_c%0d", c - 1), 64'(cursor), 64'(7'd1 << (c - 1)));
            end
        end
        chk("fill_board_full", 64'(board_full), 64'd1);
        chk("fill_occupied", 64'(occupied), {22'd0, 42'h3FF_FFFF_FFFF});
        drop(0, 1'b1);

        clear = 1'b1; btn_left = 1'b1;
        cyc();
        clear = 1'b0; btn_left = 1'b0;
        chk("clear_cursor", 64'(cursor), 64'h01);
        chk("clear_occupied", 64'(occupied), 64'd0);
        chk("clear_owner", 64'(owner), 64'd0);
        chk("clear_board_full", 64'(board_full), 64'd0);
        chk("clear_drop_row", 64'(drop_row), 64'd0);
        chk_state("clear_state", ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
